// File: rtl/xmem_dbi_pkg.sv
// -----------------------------------------------------------------------------
// xmem_dbi_pkg
// Shared definitions for the xmem write-side DBI encoder:
//   - default lane width, lanes per word and SRAM address width
//   - writer FSM state type
//   - inversion threshold: a lane inverts only on a strict majority of
//     transitions, so a tie keeps the lane as-is
// -----------------------------------------------------------------------------
package xmem_dbi_pkg;

    localparam int BW      = 4;
    localparam int ROW     = 8;
    localparam int ADDR_BW = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic logic dbi_invert(input int t, input int w);
        return (t > (w / 2));
    endfunction

endpackage

// File: rtl/dbi_lane_enc.sv
// -----------------------------------------------------------------------------
// dbi_lane_enc
// Combinational single-lane DBI encoder. Counts bit transitions between the
// new lane value and the previously written lane value and inverts the lane
// when the count exceeds half the lane width.
// Ports:
//   i_data  - raw lane value
//   i_hist  - lane value last written to the SRAM (post-encoding)
//   i_en    - encode enable; when low the lane always passes through
//   o_data  - encoded lane value
//   o_flag  - 1 when o_data is the inverse of i_data
// -----------------------------------------------------------------------------
module dbi_lane_enc
    import xmem_dbi_pkg::*;
#(
    parameter int bw = BW
)(
    input  logic [bw-1:0] i_data,
    input  logic [bw-1:0] i_hist,
    input  logic          i_en,
    output logic [bw-1:0] o_data,
    output logic          o_flag
);

    int w_cnt;

    always_comb begin
        w_cnt = 0;
        for (int k = 0; k < bw; k++) begin
            if (i_data[k] ^ i_hist[k]) w_cnt = w_cnt + 1;
        end
    end

    assign o_flag = i_en && dbi_invert(w_cnt, bw);
    assign o_data = o_flag ? ~i_data : i_data;

endmodule

// File: rtl/xmem_dbi_writer.sv
// -----------------------------------------------------------------------------
// xmem_dbi_writer
// Burst writer for the xmem SRAM with optional data-bus-inversion encoding.
// A start pulse latches base address, word count and the encode enable; each
// accepted input word is encoded against the previously written word and
// written one cycle later.
//
// Build option: XMEM_DBI_ENCODE_EN compiles in the encoder and history
// register. Without it, D carries in_data unmodified and dbi_flags is 0.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start                 - burst start pulse (IDLE only)
//   base_addr, count      - first address, number of words (0..2048)
//   dbi_en                - runtime encode enable, latched on start
//   in_valid/in_ready     - input word handshake, in_data raw word
//   CEN, WEN, A, D        - SRAM write port (active-low strobes)
//   dbi_flags             - per-lane inversion flags aligned with D
//   busy, done            - burst in progress / one-cycle completion pulse
//
// Lane g occupies in_data[(row-1-g)*bw +: bw], i.e. lane 0 is the most
// significant lane, and dbi_flags[g] belongs to lane g.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | accepting words, in_ready high
// DONE  | final write strobe on the port, done pulse
// -----------------------------------------------------------------------------
module xmem_dbi_writer
    import xmem_dbi_pkg::*;
#(
    parameter int bw      = BW,
    parameter int row     = ROW,
    parameter int addr_bw = ADDR_BW
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [addr_bw-1:0]   base_addr,
    input  logic [addr_bw:0]     count,
    input  logic                 dbi_en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [bw*row-1:0]    in_data,
    output logic                 CEN,
    output logic                 WEN,
    output logic [addr_bw-1:0]   A,
    output logic [bw*row-1:0]    D,
    output logic [row-1:0]       dbi_flags,
    output logic                 busy,
    output logic                 done
);

    localparam int W = bw * row;
    localparam logic [addr_bw-1:0] ADDR_ONE = {{(addr_bw-1){1'b0}}, 1'b1};
    localparam logic [addr_bw:0]   REM_ONE  = {{addr_bw{1'b0}}, 1'b1};

    state_t               r_state;
    state_t               w_next;
    logic [addr_bw-1:0]   r_addr;
    logic [addr_bw:0]     r_remain;
    logic                 w_start;
    logic                 w_xfer;
    logic                 w_last;
    logic [W-1:0]         w_enc;
    logic [row-1:0]       w_flags;
    logic                 r_cen;
    logic                 r_wen;
    logic [addr_bw-1:0]   r_a;
    logic [W-1:0]         r_d;
    logic [row-1:0]       r_flags;

    assign w_start = start && (r_state == IDLE);
    assign w_xfer  = in_valid && (r_state == WRITE);
    assign w_last  = (r_remain == REM_ONE);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (count == '0) ? DONE : WRITE;
            WRITE:   if (w_xfer && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (r_state == WRITE);
        busy     = (r_state == WRITE);
        done     = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (w_start) begin
            r_addr   <= base_addr;
            r_remain <= count;
        end else if (w_xfer) begin
            r_addr   <= r_addr + ADDR_ONE;
            r_remain <= r_remain - REM_ONE;
        end
    end

    // Strobes are re-armed high every cycle without a transfer; A/D/flags hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
            r_a     <= '0;
            r_d     <= '0;
            r_flags <= '0;
        end else if (w_xfer) begin
            r_cen   <= 1'b0;
            r_wen   <= 1'b0;
            r_a     <= r_addr;
            r_d     <= w_enc;
            r_flags <= w_flags;
        end else begin
            r_cen   <= 1'b1;
            r_wen   <= 1'b1;
        end
    end

`ifdef XMEM_DBI_ENCODE_EN
    logic         r_dbi_en;
    logic [W-1:0] r_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dbi_en <= 1'b0;
            r_hist   <= '0;
        end else if (w_start) begin
            r_dbi_en <= dbi_en;
            r_hist   <= '0;
        end else if (w_xfer) begin
            r_hist   <= w_enc;
        end
    end

    for (genvar g = 0; g < row; g++) begin : g_lane
        dbi_lane_enc #(.bw(bw)) u_enc (
            .i_data (in_data[(row-1-g)*bw +: bw]),
            .i_hist (r_hist[(row-1-g)*bw +: bw]),
            .i_en   (r_dbi_en),
            .o_data (w_enc[(row-1-g)*bw +: bw]),
            .o_flag (w_flags[g])
        );
    end
`else
    logic w_unused_dbi_en;

    assign w_enc           = in_data;
    assign w_flags         = '0;
    assign w_unused_dbi_en = dbi_en;
`endif

    assign CEN       = r_cen;
    assign WEN       = r_wen;
    assign A         = r_a;
    assign D         = r_d;
    assign dbi_flags = r_flags;

endmodule

// File: doc/xmem_dbi_writer.md
# xmem_dbi_writer

Write-side data-bus-inversion (DBI) encoder and address sequencer for the activation/weight SRAM (`sram_32b_w2048`). It accepts raw `bw*row`-bit words from the host stream, DBI-encodes each `bw`-bit lane against the previously written word, and drives the SRAM write port. It also emits per-lane inversion flags that the core's read-side DBI decoder consumes. It sits between the testbench/host loader and the xmem SRAM, in place of direct `D_xmem`/`CEN`/`WEN`/`A` driving.

## Interface
- `bw`, default 4: lane width in bits.
- `row`, default 8: lanes per word.
- `addr_bw`, default 11: SRAM address width (2048 entries).
- `clk`, input, 1: clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: one-cycle pulse that begins a burst. Sampled only in IDLE.
- `base_addr`, input, `addr_bw`: first write address, latched on `start`.
- `count`, input, `addr_bw+1`: number of words in the burst (0 to 2048), latched on `start`.
- `dbi_en`, input, 1: runtime encode enable, latched on `start`.
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: writer can accept a word.
- `in_data`, input, `bw*row`: raw input word.
- `CEN`, output, 1: SRAM chip enable, active low.
- `WEN`, output, 1: SRAM write enable, active low.
- `A`, output, `addr_bw`: SRAM address.
- `D`, output, `bw*row`: encoded SRAM data.
- `dbi_flags`, output, `row`: per-lane inversion flags, aligned with `D`.
- `busy`, output, 1: high in WRITE.
- `done`, output, 1: one-cycle pulse when the burst completes.

## Operation
- FSM states: IDLE, WRITE, DONE.
  - IDLE → WRITE on `start` with `count` ≠ 0.
  - IDLE → DONE on `start` with `count` = 0.
  - WRITE → DONE when the last word is accepted.
  - DONE → IDLE unconditionally, after 1 cycle.
- On `start`:
  - latch `base_addr` into the address counter, `count` into the remaining counter, and `dbi_en`;
  - clear the history register (last encoded word) to 0.
- `in_ready` = 1 only in WRITE. A transfer occurs when `in_valid && in_ready`.
- Encoding, per lane `i`:
  - `t` = popcount(`in_data` lane `i` XOR history lane `i`);
  - if latched `dbi_en` and `t > bw/2`: the lane is inverted and flag `i` = 1;
  - otherwise the lane passes through and flag `i` = 0;
  - a tie (`t == bw/2`) does not invert.
- After each transfer, the history register takes the encoded (post-inversion) word.
- After each transfer, the address increments modulo 2^`addr_bw` (2047 wraps to 0) and the remaining count decrements.
- `start` in WRITE or DONE is ignored.
- `reset` mid-burst:
  - the FSM returns to IDLE and the history register clears;
  - the in-flight registered write is dropped (`CEN`=1 on the next cycle);
  - no `done` pulse is issued.

## Timing
- Reset values:
  - `CEN`=1, `WEN`=1, `A`=0, `D`=0, `dbi_flags`=0;
  - `in_ready`=0, `busy`=0, `done`=0; FSM in IDLE.
- Latency: a transfer at cycle t drives `CEN`=0, `WEN`=0, `A`, `D` and `dbi_flags` registered at cycle t+1, for one cycle. With no transfer, `CEN`=`WEN`=1, and `A`/`D`/`dbi_flags` hold their last values.
- Throughput: 1 word per cycle with `in_valid` held high. A burst of N words has its writes at t0+1 … t0+N, where t0 is the first transfer cycle.
- `start` at cycle s makes `busy`=1 and `in_ready`=1 from s+1.
- `done`:
  - pulses in the cycle after the last transfer, coincident with the final write strobe;
  - for `count`=0, pulses at s+1 and no write occurs.
- Gaps in `in_valid` stall the burst without a timeout; the history register is preserved across gaps.

## Configuration
- `XMEM_DBI_ENCODE_EN` defined: the encoder datapath and history register are compiled in; runtime `dbi_en` selects encoding.
- Macro undefined:
  - `D` = `in_data` unmodified and `dbi_flags` is tied to 0;
  - `dbi_en` is ignored and the history register is removed;
  - FSM, counters and timing are identical.

## Structure
- Shared package `xmem_dbi_pkg`:
  - FSM state typedef (IDLE/WRITE/DONE);
  - default `BW`, `ROW`, `ADDR_BW` constants;
  - the inversion threshold function (`t > bw/2`).
- One sub-module, `dbi_lane_enc`: a combinational single-lane encoder (popcount, compare, conditional invert, flag), instantiated `row` times by a generate loop.

## Test plan
- Single word, inversion: `start`, `base_addr`=0x010, `count`=1, `dbi_en`=1, `in_data`=0xFFFF_FFFF.
  - Required at the next cycle: `A`=0x010, `D`=0x0000_0000, `dbi_flags`=0xFF, `CEN`=`WEN`=0; `done` in the same cycle.
- Tie and threshold: after history 0x0000_0000, `in_data`=0x3333_7777.
  - Required: `D`=0x3333_8888, `dbi_flags`=0xF0 (2 transitions kept, 3 inverted).
- Stall and back-to-back: `count`=4 at `base_addr`=0x7FE with `in_valid` low in cycle 2.
  - Required: addresses 0x7FE, 0x7FF, 0x000, 0x001 (wrap); no strobe during the gap; `done` exactly once.
- `dbi_en`=0: `in_data`=0xFFFF_FFFF.
  - Required: `D`=0xFFFF_FFFF, `dbi_flags`=0x00.
- Mid-burst reset: `count`=8, `reset` asserted after 3 transfers.
  - Required next cycle: `CEN`=1, `busy`=0, `in_ready`=0, no `done`.
  - A following `start` with `in_data`=0xFFFF_FFFF gives `flags`=0xFF (history cleared).
- Zero-count and ignored start: `count`=0 gives `done` at s+1 with no strobe. `start` during WRITE does not alter `A` or the remaining count.
